// File: rtl/ucsbece154b_miss_pkg.sv
// Shared types and helpers for the victim-cache miss handler.
// Holds the FSM state encoding, the line offset width and the line-alignment function.
package ucsbece154b_miss_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PROBE    = 3'd1,
    MEM_REQ  = 3'd2,
    MEM_WAIT = 3'd3,
    RESP     = 3'd4,
    DRAIN    = 3'd5
  } miss_state_e;

  localparam int LINE_WIDTH_DEFAULT = 128;

  // Byte-offset bits inside one line for the default line size.
  localparam int OFFSET_WIDTH = $clog2(LINE_WIDTH_DEFAULT / 8);

  // Byte-offset bits inside one line for an arbitrary line size.
  function automatic int offset_bits(input int line_width);
    return $clog2(line_width / 8);
  endfunction

  // Clears the low offset bits of a byte address (addresses up to 64 bits wide).
  function automatic logic [63:0] line_align(input logic [63:0] addr, input int offset);
    logic [63:0] mask;
    mask = ~((64'd1 << offset) - 64'd1);
    return addr & mask;
  endfunction

endpackage

// File: rtl/ucsbece154b_sat_counter.sv
// Saturating event counter: counts up on inc and sticks at all-ones.
module ucsbece154b_sat_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  // Increment on each event until the counter is full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= {CNT_WIDTH{1'b0}};
    end else if (inc && (count != {CNT_WIDTH{1'b1}})) begin
      count <= count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/ucsbece154b_victim_miss_handler.sv
// L1 miss handler sitting in front of a victim cache and main memory.
// A miss first probes the victim cache; only a victim miss goes to memory.
// The line displaced from L1 is written into the victim cache in the RESP cycle.
// Optional statistics counters are built when UCSBECE154B_MISS_STATS_EN is defined;
// otherwise vc_hits_o and mem_fetches_o read 0 and no counter flops exist.
module ucsbece154b_victim_miss_handler
  import ucsbece154b_miss_pkg::*;
#(
  parameter int ADDR_WIDTH = 56,
  parameter int LINE_WIDTH = 128,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic                  evict_valid_i,
  input  logic [ADDR_WIDTH-1:0] evict_addr_i,
  input  logic [LINE_WIDTH-1:0] evict_data_i,
  output logic                  resp_valid_o,
  output logic [LINE_WIDTH-1:0] resp_data_o,
  output logic                  vc_en_o,
  output logic [ADDR_WIDTH-1:0] vc_raddr_o,
  input  logic [LINE_WIDTH-1:0] vc_rdata_i,
  input  logic                  vc_hit_i,
  output logic                  vc_we_o,
  output logic [ADDR_WIDTH-1:0] vc_waddr_o,
  output logic [LINE_WIDTH-1:0] vc_wdata_o,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
  input  logic                  mem_resp_valid_i,
  input  logic [LINE_WIDTH-1:0] mem_resp_data_i,
  output logic [CNT_WIDTH-1:0]  vc_hits_o,
  output logic [CNT_WIDTH-1:0]  mem_fetches_o
);

  localparam int OFFSET_W = offset_bits(LINE_WIDTH);

  miss_state_e           state_r;
  logic                  ready_r;
  logic                  resp_valid_r;
  logic                  vc_we_r;
  logic                  mem_req_valid_r;
  logic                  en_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic                  ev_valid_r;
  logic [ADDR_WIDTH-1:0] ev_addr_r;
  logic [LINE_WIDTH-1:0] ev_data_r;
  logic [LINE_WIDTH-1:0] data_r;

  // Miss FSM with registered handshake, response and victim-write outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r         <= IDLE;
      ready_r         <= 1'b1;
      resp_valid_r    <= 1'b0;
      vc_we_r         <= 1'b0;
      mem_req_valid_r <= 1'b0;
      en_r            <= 1'b0;
      addr_r          <= {ADDR_WIDTH{1'b0}};
      mem_addr_r      <= {ADDR_WIDTH{1'b0}};
      ev_valid_r      <= 1'b0;
      ev_addr_r       <= {ADDR_WIDTH{1'b0}};
      ev_data_r       <= {LINE_WIDTH{1'b0}};
      data_r          <= {LINE_WIDTH{1'b0}};
    end else begin
      en_r         <= 1'b1;
      resp_valid_r <= 1'b0;
      vc_we_r      <= 1'b0;
      if (flush_i) begin
        mem_req_valid_r <= 1'b0;
        case (state_r)
          MEM_WAIT: begin
            // A response arriving with the flush is the one being discarded.
            if (mem_resp_valid_i) begin
              state_r <= IDLE;
              ready_r <= 1'b1;
            end else begin
              state_r <= DRAIN;
              ready_r <= 1'b0;
            end
          end
          MEM_REQ: begin
            // Memory already owes us a line if the handshake landed this cycle.
            if (mem_req_ready_i) begin
              state_r <= DRAIN;
              ready_r <= 1'b0;
            end else begin
              state_r <= IDLE;
              ready_r <= 1'b1;
            end
          end
          DRAIN: begin
            if (mem_resp_valid_i) begin
              state_r <= IDLE;
              ready_r <= 1'b1;
            end else begin
              state_r <= DRAIN;
              ready_r <= 1'b0;
            end
          end
          default: begin
            state_r <= IDLE;
            ready_r <= 1'b1;
          end
        endcase
      end else begin
        case (state_r)
          IDLE: begin
            if (req_valid_i) begin
              addr_r     <= req_addr_i;
              mem_addr_r <= ADDR_WIDTH'(line_align(64'(req_addr_i), OFFSET_W));
              ev_valid_r <= evict_valid_i;
              ev_addr_r  <= evict_addr_i;
              ev_data_r  <= evict_data_i;
              ready_r    <= 1'b0;
              state_r    <= PROBE;
            end else begin
              ready_r <= 1'b1;
              state_r <= IDLE;
            end
          end
          PROBE: begin
            if (vc_hit_i) begin
              data_r       <= vc_rdata_i;
              resp_valid_r <= 1'b1;
              vc_we_r      <= ev_valid_r;
              state_r      <= RESP;
            end else begin
              mem_req_valid_r <= 1'b1;
              state_r         <= MEM_REQ;
            end
          end
          MEM_REQ: begin
            if (mem_req_ready_i) begin
              mem_req_valid_r <= 1'b0;
              state_r         <= MEM_WAIT;
            end else begin
              mem_req_valid_r <= 1'b1;
              state_r         <= MEM_REQ;
            end
          end
          MEM_WAIT: begin
            if (mem_resp_valid_i) begin
              data_r       <= mem_resp_data_i;
              resp_valid_r <= 1'b1;
              vc_we_r      <= ev_valid_r;
              state_r      <= RESP;
            end else begin
              state_r <= MEM_WAIT;
            end
          end
          RESP: begin
            ready_r <= 1'b1;
            state_r <= IDLE;
          end
          DRAIN: begin
            if (mem_resp_valid_i) begin
              ready_r <= 1'b1;
              state_r <= IDLE;
            end else begin
              state_r <= DRAIN;
            end
          end
          default: begin
            mem_req_valid_r <= 1'b0;
            ready_r         <= 1'b1;
            state_r         <= IDLE;
          end
        endcase
      end
    end
  end

  // Flush suppresses any in-flight response/victim write and disables the victim cache.
  assign req_ready_o     = ready_r & ~flush_i;
  assign resp_valid_o    = resp_valid_r & ~flush_i;
  assign vc_we_o         = vc_we_r & ~flush_i;
  assign vc_en_o         = en_r & ~flush_i;
  assign resp_data_o     = data_r;
  assign vc_raddr_o      = addr_r;
  assign vc_waddr_o      = ev_addr_r;
  assign vc_wdata_o      = ev_data_r;
  assign mem_req_valid_o = mem_req_valid_r;
  assign mem_req_addr_o  = mem_addr_r;

`ifdef UCSBECE154B_MISS_STATS_EN
  logic hit_inc;
  logic fetch_inc;

  assign hit_inc   = (state_r == PROBE) && !flush_i && vc_hit_i;
  assign fetch_inc = (state_r == MEM_REQ) && mem_req_ready_i;

  ucsbece154b_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_hit_cnt (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .inc   (hit_inc),
    .count (vc_hits_o)
  );

  ucsbece154b_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_fetch_cnt (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .inc   (fetch_inc),
    .count (mem_fetches_o)
  );
`else
  assign vc_hits_o     = {CNT_WIDTH{1'b0}};
  assign mem_fetches_o = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_ucsbece154b_victim_miss_handler.sv
// Directed bench for the victim-cache miss handler: a vector table of victim
// hits and misses plus hand-written flush and reset sequences.
module tb_ucsbece154b_victim_miss_handler;

  localparam int AW = 56;
  localparam int LW = 128;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          flush_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [AW-1:0] req_addr_i;
  logic          evict_valid_i;
  logic [AW-1:0] evict_addr_i;
  logic [LW-1:0] evict_data_i;
  logic          resp_valid_o;
  logic [LW-1:0] resp_data_o;
  logic          vc_en_o;
  logic [AW-1:0] vc_raddr_o;
  logic [LW-1:0] vc_rdata_i;
  logic          vc_hit_i;
  logic          vc_we_o;
  logic [AW-1:0] vc_waddr_o;
  logic [LW-1:0] vc_wdata_o;
  logic          mem_req_valid_o;
  logic          mem_req_ready_i;
  logic [AW-1:0] mem_req_addr_o;
  logic          mem_resp_valid_i;
  logic [LW-1:0] mem_resp_data_i;
  logic [CW-1:0] vc_hits_o;
  logic [CW-1:0] mem_fetches_o;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_hits = 0;
  int exp_fetches = 0;

  always #5 clk = ~clk;

  ucsbece154b_victim_miss_handler #(
    .ADDR_WIDTH (AW),
    .LINE_WIDTH (LW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .flush_i          (flush_i),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_addr_i       (req_addr_i),
    .evict_valid_i    (evict_valid_i),
    .evict_addr_i     (evict_addr_i),
    .evict_data_i     (evict_data_i),
    .resp_valid_o     (resp_valid_o),
    .resp_data_o      (resp_data_o),
    .vc_en_o          (vc_en_o),
    .vc_raddr_o       (vc_raddr_o),
    .vc_rdata_i       (vc_rdata_i),
    .vc_hit_i         (vc_hit_i),
    .vc_we_o          (vc_we_o),
    .vc_waddr_o       (vc_waddr_o),
    .vc_wdata_o       (vc_wdata_o),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_req_addr_o   (mem_req_addr_o),
    .mem_resp_valid_i (mem_resp_valid_i),
    .mem_resp_data_i  (mem_resp_data_i),
    .vc_hits_o        (vc_hits_o),
    .mem_fetches_o    (mem_fetches_o)
  );

  typedef struct {
    logic          hit;
    logic [AW-1:0] addr;
    logic [LW-1:0] vc_data;
    logic          ev;
    logic [AW-1:0] ev_addr;
    logic [LW-1:0] ev_data;
    int            ready_dly;
    int            resp_dly;
    logic [LW-1:0] mem_data;
    logic [LW-1:0] exp_data;
    logic [AW-1:0] exp_mem_addr;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(input logic hit, input logic [AW-1:0] addr, input logic [LW-1:0] vc_data,
                              input logic ev, input logic [AW-1:0] ev_addr, input logic [LW-1:0] ev_data,
                              input int ready_dly, input int resp_dly, input logic [LW-1:0] mem_data,
                              input logic [LW-1:0] exp_data, input logic [AW-1:0] exp_mem_addr);
    vec_t v;
    v.hit = hit; v.addr = addr; v.vc_data = vc_data; v.ev = ev; v.ev_addr = ev_addr;
    v.ev_data = ev_data; v.ready_dly = ready_dly; v.resp_dly = resp_dly; v.mem_data = mem_data;
    v.exp_data = exp_data; v.exp_mem_addr = exp_mem_addr;
    return v;
  endfunction

  function automatic int sat3(input int n);
    return (n > 3) ? 3 : n;
  endfunction

  task automatic checkb(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkw(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_counters();
`ifdef UCSBECE154B_MISS_STATS_EN
    checkw("vc_hits", LW'(vc_hits_o), LW'(sat3(exp_hits)));
    checkw("mem_fetches", LW'(mem_fetches_o), LW'(sat3(exp_fetches)));
`else
    checkw("vc_hits_tied", LW'(vc_hits_o), LW'(0));
    checkw("mem_fetches_tied", LW'(mem_fetches_o), LW'(0));
`endif
  endtask

  // One complete miss transaction from acceptance to the return to IDLE.
  task automatic run_txn(input vec_t v);
    @(negedge clk);
    checkb("req_ready_idle", req_ready_o, 1'b1);
    req_valid_i   = 1'b1;
    req_addr_i    = v.addr;
    evict_valid_i = v.ev;
    evict_addr_i  = v.ev_addr;
    evict_data_i  = v.ev_data;
    vc_hit_i      = v.hit;
    vc_rdata_i    = v.vc_data;
    @(posedge clk); #1;
    req_valid_i   = 1'b0;
    req_addr_i    = ~v.addr;
    evict_valid_i = 1'b0;
    evict_addr_i  = ~v.ev_addr;
    evict_data_i  = ~v.ev_data;
    @(negedge clk);
    checkw("probe_addr", LW'(vc_raddr_o), LW'(v.addr));
    checkb("probe_no_resp", resp_valid_o, 1'b0);
    checkb("probe_no_mem", mem_req_valid_o, 1'b0);
    checkb("probe_not_ready", req_ready_o, 1'b0);
    @(posedge clk);
    @(negedge clk);
    if (v.hit) begin
      exp_hits++;
    end else begin
      checkb("mem_req_valid", mem_req_valid_o, 1'b1);
      checkw("mem_req_addr", LW'(mem_req_addr_o), LW'(v.exp_mem_addr));
      checkb("mem_req_no_resp", resp_valid_o, 1'b0);
      for (int i = 0; i < v.ready_dly; i++) begin
        @(posedge clk);
        @(negedge clk);
        checkb("mem_req_hold", mem_req_valid_o, 1'b1);
        checkw("mem_req_addr_hold", LW'(mem_req_addr_o), LW'(v.exp_mem_addr));
      end
      mem_req_ready_i = 1'b1;
      @(posedge clk); #1;
      mem_req_ready_i = 1'b0;
      exp_fetches++;
      @(negedge clk);
      checkb("mem_req_drop", mem_req_valid_o, 1'b0);
      for (int i = 0; i < v.resp_dly; i++) begin
        @(posedge clk);
        @(negedge clk);
        checkb("mem_wait_no_resp", resp_valid_o, 1'b0);
      end
      mem_resp_valid_i = 1'b1;
      mem_resp_data_i  = v.mem_data;
      @(posedge clk); #1;
      mem_resp_valid_i = 1'b0;
      mem_resp_data_i  = ~v.mem_data;
      @(negedge clk);
    end
    checkb("resp_valid", resp_valid_o, 1'b1);
    checkw("resp_data", resp_data_o, v.exp_data);
    checkb("resp_no_mem", mem_req_valid_o, 1'b0);
    checkb("resp_vc_we", vc_we_o, v.ev);
    if (v.ev) begin
      checkw("vc_waddr", LW'(vc_waddr_o), LW'(v.ev_addr));
      checkw("vc_wdata", vc_wdata_o, v.ev_data);
    end
    @(posedge clk);
    @(negedge clk);
    checkb("resp_pulse_end", resp_valid_o, 1'b0);
    checkb("vc_we_pulse_end", vc_we_o, 1'b0);
    checkb("ready_after_resp", req_ready_o, 1'b1);
    check_counters();
    vc_hit_i = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; req_valid_i = 1'b0; req_addr_i = '0;
    evict_valid_i = 1'b0; evict_addr_i = '0; evict_data_i = '0;
    vc_rdata_i = '0; vc_hit_i = 1'b0; mem_req_ready_i = 1'b0;
    mem_resp_valid_i = 1'b0; mem_resp_data_i = '0;

    vecs[0] = mk(1'b1, 56'h2040, 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA, 1'b0, 56'h0, 128'h0,
                 0, 0, 128'h0, 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA, 56'h0);
    vecs[1] = mk(1'b0, 56'h3000, 128'hDEAD_DEAD_DEAD_DEAD_DEAD_DEAD_DEAD_DEAD, 1'b1, 56'h1000,
                 128'h5555_5555_5555_5555_5555_5555_5555_5555, 3, 0,
                 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, 56'h3000);
    vecs[2] = mk(1'b0, 56'h1007, 128'h0, 1'b0, 56'h0, 128'h0, 5, 2,
                 128'hCAFE_BABE_0000_1111_2222_3333_4444_5555, 128'hCAFE_BABE_0000_1111_2222_3333_4444_5555, 56'h1000);
    vecs[3] = mk(1'b1, 56'h4, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b1, 56'h8000,
                 128'hF0F0_F0F0_F0F0_F0F0_F0F0_F0F0_F0F0_F0F0, 0, 0, 128'h0,
                 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 56'h0);
    vecs[4] = mk(1'b1, 56'h40, 128'h0BAD_F00D_0BAD_F00D_0BAD_F00D_0BAD_F00D, 1'b0, 56'h0, 128'h0,
                 0, 0, 128'h0, 128'h0BAD_F00D_0BAD_F00D_0BAD_F00D_0BAD_F00D, 56'h0);
    vecs[5] = mk(1'b1, 56'h50, 128'h1, 1'b1, 56'h9010, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF,
                 0, 0, 128'h0, 128'h1, 56'h0);
    vecs[6] = mk(1'b1, 56'h60, 128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0, 56'h0, 128'h0,
                 0, 0, 128'h0, 128'h8000_0000_0000_0000_0000_0000_0000_0000, 56'h0);
    vecs[7] = mk(1'b0, 56'hFF_FFFF_FFFF_FFFF, 128'h0, 1'b1, 56'hA0A0,
                 128'h5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A, 0, 1,
                 128'hFEDC_BA98_7654_3210_FEDC_BA98_7654_3210, 128'hFEDC_BA98_7654_3210_FEDC_BA98_7654_3210,
                 56'hFF_FFFF_FFFF_FFF0);

    // Reset state.
    repeat (2) @(negedge clk);
    checkb("rst_req_ready", req_ready_o, 1'b1);
    checkb("rst_resp_valid", resp_valid_o, 1'b0);
    checkb("rst_vc_we", vc_we_o, 1'b0);
    checkb("rst_mem_req", mem_req_valid_o, 1'b0);
    checkb("rst_vc_en", vc_en_o, 1'b0);
    checkw("rst_resp_data", resp_data_o, LW'(0));
    check_counters();
    rst_ni = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkb("vc_en_after_rst", vc_en_o, 1'b1);

    // Vector table: hits, misses, unaligned and top-of-range addresses.
    for (int k = 0; k < 8; k++) begin
      run_txn(vecs[k]);
    end

    // Flush while waiting for memory: response must be swallowed.
    @(negedge clk);
    req_valid_i = 1'b1; req_addr_i = 56'h5008; evict_valid_i = 1'b1;
    evict_addr_i = 56'h6000; evict_data_i = 128'h7777_7777_7777_7777_7777_7777_7777_7777;
    vc_hit_i = 1'b0;
    @(posedge clk); #1;
    req_valid_i = 1'b0; evict_valid_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkw("flush_mem_addr", LW'(mem_req_addr_o), LW'(56'h5000));
    mem_req_ready_i = 1'b1;
    @(posedge clk); #1;
    mem_req_ready_i = 1'b0;
    exp_fetches++;
    @(negedge clk);
    flush_i = 1'b1;
    #1;
    checkb("flush_vc_en_low", vc_en_o, 1'b0);
    checkb("flush_no_resp", resp_valid_o, 1'b0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    @(negedge clk);
    checkb("drain_vc_en", vc_en_o, 1'b1);
    checkb("drain_not_ready", req_ready_o, 1'b0);
    @(posedge clk);
    @(negedge clk);
    mem_resp_valid_i = 1'b1;
    mem_resp_data_i  = 128'h9999_9999_9999_9999_9999_9999_9999_9999;
    @(posedge clk); #1;
    mem_resp_valid_i = 1'b0;
    @(negedge clk);
    checkb("drain_no_resp", resp_valid_o, 1'b0);
    checkb("drain_no_we", vc_we_o, 1'b0);
    checkb("drain_ready", req_ready_o, 1'b1);
    @(posedge clk);
    @(negedge clk);
    checkb("drain_still_no_resp", resp_valid_o, 1'b0);
    check_counters();

    // Stray memory response in IDLE is ignored.
    mem_resp_valid_i = 1'b1;
    @(posedge clk); #1;
    mem_resp_valid_i = 1'b0;
    @(negedge clk);
    checkb("stray_no_resp", resp_valid_o, 1'b0);
    checkb("stray_ready", req_ready_o, 1'b1);

    // Reset in the middle of a memory request.
    req_valid_i = 1'b1; req_addr_i = 56'h7010; vc_hit_i = 1'b0;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkb("pre_rst_mem_req", mem_req_valid_o, 1'b1);
    rst_ni = 1'b0;
    #1;
    exp_hits = 0;
    exp_fetches = 0;
    checkb("arst_mem_req", mem_req_valid_o, 1'b0);
    checkb("arst_req_ready", req_ready_o, 1'b1);
    checkb("arst_resp", resp_valid_o, 1'b0);
    checkb("arst_vc_we", vc_we_o, 1'b0);
    checkb("arst_vc_en", vc_en_o, 1'b0);
    checkw("arst_raddr", LW'(vc_raddr_o), LW'(0));
    checkw("arst_mem_addr", LW'(mem_req_addr_o), LW'(0));
    check_counters();
    @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkb("vc_en_after_arst", vc_en_o, 1'b1);
    run_txn(vecs[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
